traffic_phase_scheduler: RTL
============================

// Module: traffic_phase_scheduler
// PURPOSE
//   Sequences a two-axis intersection (EW = bit 1, SN = bit 0) through an
//   8-phase, 120 s default cycle: green, yellow, left-turn, yellow per axis.
//   Derives a 1 s tick from clk, latches pedestrian requests, and grants an
//   emergency all-red preemption. Drives the lamp bus G/Y/R/L directly.
// PARAMETERS
//   TICK_DIV  50_000_000  clk cycles per 1 s tick (sim: 4); must be >= 2
//   G_EW_S    40          EW green seconds
//   G_SN_S    30          SN green seconds
//   Y_S       5           every yellow phase, seconds
//   L_S       15          every left-turn phase, seconds
//   ALLRED_S  3           all-red hold after emergency release, seconds
//   All durations are in the range 1..127.
// PORTS
//   clk       in   1  system clock
//   rst       in   1  synchronous reset, active-low
//   en        in   1  1 = run; 0 = freeze prescaler, phase and sec_left
//   ped_req   in   2  pedestrian request pulse/level per axis
//   emerg     in   1  emergency preempt, level
//   G,Y,R,L   out  2  lamp outputs: bit1 = EW, bit0 = SN
//   ped_walk  out  2  walk indication per axis
//   phase     out  4  current state encoding (see below)
//   sec_left  out  7  seconds remaining in the current phase
// BEHAVIOUR
//   Reset (rst == 0 at posedge clk):
//     phase = EW_G, sec_left = G_EW_S, prescaler = 0, ped latches = 0,
//     G = 10, R = 01, Y = 00, L = 00, ped_walk = 00.
//   Tick: prescaler counts 0..TICK_DIV-1 while en = 1. tick = 1 for one
//     cycle when the count wraps. en = 0 holds everything except the ped latches.
//   States, durations and successors:
//     0 EW_G (G_EW_S) -> 1 EW_Y1 (Y_S) -> 2 EW_L (L_S) -> 3 EW_Y2 (Y_S)
//     -> 4 SN_G (G_SN_S) -> 5 SN_Y1 -> 6 SN_L -> 7 SN_Y2 -> 0
//     8 ALL_RED: entered only through emerg.
//   Phase advance: on a tick with sec_left == 1, move to the next phase and
//     load its duration. Otherwise a tick decrements sec_left.
//   Lamp decode (a Moore output that changes on the same edge as phase):
//     states 0-3: R = 01; EW lamp G/Y/L = 10 for G/Y/L phases respectively.
//     states 4-7: R = 10; SN lamp = 01 likewise.
//     ALL_RED: R = 11, G = Y = L = 00.
//     In every state exactly one lamp per axis is lit.
//   Pedestrian: ped_req[a] sets latch[a] on any cycle.
//     On entry to axis a's green: ped_walk[a] = latch[a] for the whole green,
//     and latch[a] clears on that same edge. A request arriving during a
//     green is held for the next cycle.
//     ped_walk = 00 outside green phases.
//   Emergency: emerg = 1 sampled at any posedge (en is ignored) -> next
//     state is ALL_RED and the prescaler clears. While emerg = 1, sec_left
//     holds at ALLRED_S. After emerg falls, the tick runs and the block
//     leaves ALL_RED after ALLRED_S ticks into EW_G with sec_left = G_EW_S.
//     A re-assertion during the hold reloads ALLRED_S.
//   Priority: rst > emerg > en/tick.
//     A tick and emerg in the same cycle: emerg wins.
// TESTING (TICK_DIV = 4, default durations)
//   1 Reset release, en = 1: G = 10, R = 01 for 160 cycles. Then Y = 10 for
//     20 cycles, L = 10 for 60, Y = 10 for 20, then G = 01, R = 10.
//     Period 480 cycles.
//   2 Full cycle: phase sequence 0..7 then 0. sec_left reads 40,39..1 in EW_G.
//     Assert one lamp per axis every cycle.
//   3 ped_req = 01 pulse during EW_G -> ped_walk = 01 for all of SN_G
//     (120 cycles), then 00. A second pulse mid-SN_G shows at the next SN_G.
//   4 emerg = 1 mid EW_L -> next cycle R = 11, phase = 8. Release -> 12 cycles
//     later phase = 0, G = 10.
//   5 en = 0 for 50 cycles mid SN_Y1 -> phase/sec_left frozen, resumes unchanged.
//   6 rst = 0 for one cycle mid SN_L -> phase 0, sec_left 40, ped_walk 00.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Two-axis intersection phase sequencer with 1 s tick, ped latches and emergency all-red.
// Ports: clk, rst (sync, active-low), en, ped_req[1:0], emerg -> G/Y/R/L[1:0], ped_walk[1:0], phase[3:0], sec_left[6:0].
module traffic_phase_scheduler #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned G_EW_S   = 40,
   parameter int unsigned G_SN_S   = 30,
   parameter int unsigned Y_S      = 5,
   parameter int unsigned L_S      = 15,
   parameter int unsigned ALLRED_S = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] ped_req,
   input  logic       emerg,
   output logic [1:0] G,
   output logic [1:0] Y,
   output logic [1:0] R,
   output logic [1:0] L,
   output logic [1:0] ped_walk,
   output logic [3:0] phase,
   output logic [6:0] sec_left
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   typedef enum logic [3:0] {
      EW_G    = 4'd0,
      EW_Y1   = 4'd1,
      EW_L    = 4'd2,
      EW_Y2   = 4'd3,
      SN_G    = 4'd4,
      SN_Y1   = 4'd5,
      SN_L    = 4'd6,
      SN_Y2   = 4'd7,
      ALL_RED = 4'd8
   } state_t;

   state_t        state_q;
   state_t        state_d;
   state_t        succ_s;
   logic [6:0]    sec_q;
   logic [6:0]    sec_d;
   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;
   logic [1:0]    latch_q;
   logic [1:0]    latch_d;
   logic [1:0]    walk_q;
   logic [1:0]    walk_d;
   logic          tick;
   logic          ent_ew;
   logic          ent_sn;

   function automatic state_t succ(input state_t s);
      state_t n;
      case (s)
         EW_G:    n = EW_Y1;
         EW_Y1:   n = EW_L;
         EW_L:    n = EW_Y2;
         EW_Y2:   n = SN_G;
         SN_G:    n = SN_Y1;
         SN_Y1:   n = SN_L;
         SN_L:    n = SN_Y2;
         default: n = EW_G;
      endcase
      return n;
   endfunction

   function automatic logic [6:0] dur(input state_t s);
      logic [6:0] d;
      case (s)
         EW_G:                       d = 7'(G_EW_S);
         SN_G:                       d = 7'(G_SN_S);
         EW_Y1, EW_Y2, SN_Y1, SN_Y2: d = 7'(Y_S);
         EW_L, SN_L:                 d = 7'(L_S);
         default:                    d = 7'(ALLRED_S);
      endcase
      return d;
   endfunction

   // Phase, countdown and prescaler; emerg overrides en and tick.
   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      pre_d   = pre_q;
      succ_s  = succ(state_q);
      tick    = en && (pre_q == PMAX);
      if (emerg) begin
         state_d = ALL_RED;
         sec_d   = 7'(ALLRED_S);
         pre_d   = '0;
      end else if (en) begin
         pre_d = tick ? '0 : pre_q + PW'(1);
         if (tick) begin
            if (sec_q == 7'd1) begin
               state_d = succ_s;
               sec_d   = dur(succ_s);
            end else begin
               sec_d = sec_q - 7'd1;
            end
         end
      end
   end

   // Walk is captured from the latch on the edge that enters a green
   // and cleared whenever the next state is not that axis' green.
   always_comb begin
      ent_ew  = (state_d == EW_G) && (state_q != EW_G);
      ent_sn  = (state_d == SN_G) && (state_q != SN_G);
      latch_d = (latch_q & ~{ent_ew, ent_sn}) | ped_req;
      walk_d  = 2'b00;
      if (state_d == EW_G) begin
         walk_d[1] = ent_ew ? latch_q[1] : walk_q[1];
      end
      if (state_d == SN_G) begin
         walk_d[0] = ent_sn ? latch_q[0] : walk_q[0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= EW_G;
         sec_q   <= 7'(G_EW_S);
         pre_q   <= '0;
         latch_q <= 2'b00;
         walk_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         pre_q   <= pre_d;
         latch_q <= latch_d;
         walk_q  <= walk_d;
      end
   end

   // Lamp decode from the registered phase; unknown codes show all red.
   always_comb begin
      G = 2'b00;
      Y = 2'b00;
      R = 2'b00;
      L = 2'b00;
      case (state_q)
         EW_G: begin
            G = 2'b10;
            R = 2'b01;
         end
         EW_Y1, EW_Y2: begin
            Y = 2'b10;
            R = 2'b01;
         end
         EW_L: begin
            L = 2'b10;
            R = 2'b01;
         end
         SN_G: begin
            G = 2'b01;
            R = 2'b10;
         end
         SN_Y1, SN_Y2: begin
            Y = 2'b01;
            R = 2'b10;
         end
         SN_L: begin
            L = 2'b01;
            R = 2'b10;
         end
         default: R = 2'b11;
      endcase
   end

   assign phase    = state_q;
   assign sec_left = sec_q;
   assign ped_walk = walk_q;

endmodule
